// File: rtl/dmem_lsu_ctrl.sv
// dmem_lsu_ctrl: handshaked RV32I data-memory controller with wait states and fault detection
module dmem_lsu_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_fault_o
);
  localparam int DEPTH = 2 ** (ADDR_W - 2);
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_e;
  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [2:0]        funct_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic [31:0]       mem_q [DEPTH];
  logic              accept, req_fault;
  logic [1:0]        rb, b;
  logic [31:0]       word, ld, wd;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [3:0]        be;

  assign accept       = (state_q == IDLE) && req_valid_i;
  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_fault_o = fault_q;

  // Illegal funct3 codes first, then alignment for half/word sizes.
  assign rb        = req_addr_i[1:0];
  assign req_fault = (req_we_i ? (req_funct_i[2] | &req_funct_i[1:0])
                               : (&req_funct_i[1:0] | &req_funct_i[2:1]))
                   | ((req_funct_i[1:0] == 2'b01) & rb[0])
                   | ((req_funct_i[1:0] == 2'b10) & |rb);

  assign b      = addr_q[1:0];
  assign word   = mem_q[addr_q[ADDR_W-1:2]];
  assign byte_v = word[{b, 3'b000} +: 8];
  assign half_v = word[{b[1], 4'b0000} +: 16];
  assign ld     = funct_q[1] ? word
                : funct_q[0] ? {{16{~funct_q[2] & half_v[15]}}, half_v}
                :              {{24{~funct_q[2] & byte_v[7]}}, byte_v};
  assign be     = funct_q[1] ? 4'hF : funct_q[0] ? (b[1] ? 4'hC : 4'h3) : (4'b0001 << b);
  assign wd     = funct_q[1] ? wdata_q : funct_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: if (req_valid_i) begin
        rdata_d = '0;
        fault_d = req_fault;
        cnt_d   = 3'(WAIT_CYC - 1);
        state_d = req_fault ? RESP : (WAIT_CYC == 0) ? ACCESS : WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q - 3'd1;
        state_d = (cnt_q == 3'd0) ? ACCESS : WAIT;
      end
      ACCESS: begin
        rdata_d = we_q ? '0 : ld;
        state_d = RESP;
      end
      default: if (resp_ready_i) begin
        rdata_d = '0;
        fault_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      funct_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      if (accept) begin
        we_q    <= req_we_i;
        funct_q <= req_funct_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (state_q == ACCESS && we_q) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem_q[addr_q[ADDR_W-1:2]][8*i +: 8] <= wd[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// tb_dmem_lsu_ctrl: directed checks of the data-memory controller with three wait states
module tb_dmem_lsu_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
  logic [2:0]  req_funct = '0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  int          n_cmp = 0, n_bad = 0;

  dmem_lsu_ctrl #(.ADDR_W(10), .WAIT_CYC(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_funct_i(req_funct), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata),
    .resp_fault_o(resp_fault)
  );

  always #5 clk = ~clk;

  task automatic xact(input logic we, input logic [2:0] f, input logic [9:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic flt, output int lat);
    @(negedge clk);
    req_we = we; req_funct = f; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!resp_valid && lat < 40) begin @(negedge clk); lat++; end
    rd = resp_rdata; flt = resp_fault;
    resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset req_ready: got %b want 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset resp_valid: got %b want 0", resp_valid); end
    n_cmp++; if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset resp_rdata: got %h want 0", resp_rdata); end
    n_cmp++; if (resp_fault !== 1'b0) begin n_bad++; $display("FAIL reset resp_fault: got %b want 0", resp_fault); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic flt; int lat;
    xact(1'b1, 3'b010, 10'h010, 32'hDEADBEEF, rd, flt, lat);
    n_cmp++; if (flt !== 1'b0 || rd !== 32'h0) begin n_bad++; $display("FAIL sw_010 resp: got fault=%b rdata=%h want 0/0", flt, rd); end
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL sw_010 latency: got %0d want 5", lat); end
    xact(1'b0, 3'b010, 10'h010, 32'h0, rd, flt, lat);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_010 rdata: got %h want deadbeef", rd); end
    n_cmp++; if (flt !== 1'b0) begin n_bad++; $display("FAIL lw_010 fault: got %b want 0", flt); end
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL lw_010 latency: got %0d want 5", lat); end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic flt; int lat;
    xact(1'b1, 3'b000, 10'h013, 32'h00000080, rd, flt, lat);
    xact(1'b0, 3'b000, 10'h013, 32'h0, rd, flt, lat);
    n_cmp++; if (rd !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_013: got %h want ffffff80", rd); end
    xact(1'b0, 3'b100, 10'h013, 32'h0, rd, flt, lat);
    n_cmp++; if (rd !== 32'h00000080) begin n_bad++; $display("FAIL lbu_013: got %h want 00000080", rd); end
    xact(1'b0, 3'b010, 10'h010, 32'h0, rd, flt, lat);
    n_cmp++; if (rd !== 32'h80ADBEEF) begin n_bad++; $display("FAIL lw_after_sb: got %h want 80adbeef", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic flt; int lat;
    xact(1'b1, 3'b001, 10'h012, 32'h00001234, rd, flt, lat);
    xact(1'b0, 3'b101, 10'h012, 32'h0, rd, flt, lat);
    n_cmp++; if (rd !== 32'h00001234) begin n_bad++; $display("FAIL lhu_012: got %h want 00001234", rd); end
    xact(1'b0, 3'b010, 10'h010, 32'h0, rd, flt, lat);
    n_cmp++; if (rd !== 32'h1234BEEF) begin n_bad++; $display("FAIL lw_after_sh: got %h want 1234beef", rd); end
    xact(1'b0, 3'b001, 10'h011, 32'h0, rd, flt, lat);
    n_cmp++; if (flt !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL lh_011 misaligned: got fault=%b rdata=%h want 1/0", flt, rd); end
    xact(1'b0, 3'b001, 10'h012, 32'h0, rd, flt, lat);
    n_cmp++; if (rd !== 32'h00001234) begin n_bad++; $display("FAIL lh_012: got %h want 00001234", rd); end
  endtask

  task automatic test_fault();
    logic [31:0] rd; logic flt; int lat;
    xact(1'b1, 3'b010, 10'h022, 32'hFFFFFFFF, rd, flt, lat);
    n_cmp++; if (flt !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL sw_022 fault: got fault=%b rdata=%h want 1/0", flt, rd); end
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL sw_022 latency: got %0d want 1", lat); end
    xact(1'b0, 3'b010, 10'h020, 32'h0, rd, flt, lat);
    n_cmp++; if (rd !== 32'h0 || flt !== 1'b0) begin n_bad++; $display("FAIL lw_020 untouched: got rdata=%h fault=%b want 0/0", rd, flt); end
    xact(1'b0, 3'b011, 10'h010, 32'h0, rd, flt, lat);
    n_cmp++; if (flt !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL load_f011: got fault=%b rdata=%h want 1/0", flt, rd); end
    xact(1'b1, 3'b100, 10'h010, 32'h55555555, rd, flt, lat);
    n_cmp++; if (flt !== 1'b1) begin n_bad++; $display("FAIL store_f100: got fault=%b want 1", flt); end
    xact(1'b1, 3'b001, 10'h011, 32'h0000AAAA, rd, flt, lat);
    n_cmp++; if (flt !== 1'b1) begin n_bad++; $display("FAIL sh_011: got fault=%b want 1", flt); end
    xact(1'b0, 3'b010, 10'h010, 32'h0, rd, flt, lat);
    n_cmp++; if (rd !== 32'h1234BEEF) begin n_bad++; $display("FAIL lw_after_faults: got %h want 1234beef", rd); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    req_we = 1'b0; req_funct = 3'b010; req_addr = 10'h010; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!resp_valid && lat < 40) begin @(negedge clk); lat++; end
    req_we = 1'b0; req_funct = 3'b100; req_addr = 10'h012; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL stall resp_valid c%0d: got %b want 1", i, resp_valid); end
      n_cmp++; if (resp_rdata !== 32'h1234BEEF) begin n_bad++; $display("FAIL stall rdata c%0d: got %h want 1234beef", i, resp_rdata); end
      n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL stall req_ready c%0d: got %b want 0", i, req_ready); end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_bad++; $display("FAIL post_handshake: got ready=%b valid=%b want 1/0", req_ready, resp_valid); end
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!resp_valid && lat < 40) begin @(negedge clk); lat++; end
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL b2b latency: got %0d want 5", lat); end
    n_cmp++; if (resp_rdata !== 32'h00000034) begin n_bad++; $display("FAIL b2b lbu_012: got %h want 00000034", resp_rdata); end
    resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; logic flt; int lat;
    @(negedge clk);
    req_we = 1'b0; req_funct = 3'b010; req_addr = 10'h010; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL wait req_ready: got %b want 0", req_ready); end
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_reset req_ready: got %b want 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset resp_valid: got %b want 0", resp_valid); end
    @(negedge clk); rst_n = 1'b1;
    repeat (8) @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL dropped_req responded: got %b want 0", resp_valid); end
    xact(1'b0, 3'b010, 10'h010, 32'h0, rd, flt, lat);
    n_cmp++; if (rd !== 32'h0 || flt !== 1'b0) begin n_bad++; $display("FAIL lw_010 cleared: got rdata=%h fault=%b want 0/0", rd, flt); end
    xact(1'b0, 3'b010, 10'h3FC, 32'h0, rd, flt, lat);
    n_cmp++; if (rd !== 32'h0 || lat !== 5) begin n_bad++; $display("FAIL lw_3fc cleared: got rdata=%h lat=%0d want 0/5", rd, lat); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_fault();
    test_back_to_back();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
